// File: rtl/fsm_pkg.sv
// Shared definitions for the sequence-FSM sequencer: controller states,
// FSM output symbol encodings and the legal parameter ranges.
package fsm_pkg;

  // Sequencer controller states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  // 2-bit output symbols produced by the sequence FSM
  localparam logic [1:0] SYM0 = 2'd0;
  localparam logic [1:0] SYM1 = 2'd1;
  localparam logic [1:0] SYM2 = 2'd2;
  localparam logic [1:0] SYM3 = 2'd3;

  // Supported ranges for pattern length and FSM output latency
  localparam int N_MIN   = 2;
  localparam int N_MAX   = 32;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

endpackage

// File: rtl/fsm_capture_pipe.sv
// Delay line that follows each driven pattern bit for LAT cycles so the
// parent knows exactly when, and into which slot, the FSM output lands.
module fsm_capture_pipe #(
  parameter int LAT = 1,
  parameter int IW  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld_i,
  input  logic [IW-1:0] idx_i,
  output logic          vld_o,
  output logic [IW-1:0] idx_o
);

  logic [LAT-1:0] vld_q;
  logic [IW-1:0]  idx_q [LAT];

  // Shift the (valid, index) pair one stage per cycle; reset empties the line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= vld_i;
      idx_q[0] <= idx_i;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign vld_o = vld_q[LAT-1];
  assign idx_o = idx_q[LAT-1];

endmodule

// File: rtl/fsm_seq_ctrl.sv
// Sequencer that restarts a 1-in/2-out Mealy FSM, shifts an N-bit pattern
// into it LSB first, and gathers every FSM output into a result word plus
// counts of symbol 1 and symbol 2 outputs.
module fsm_seq_ctrl
  import fsm_pkg::*;
#(
  parameter int N   = 8,
  parameter int LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N-1:0]           pattern,
  output logic                   busy,
  output logic                   done,
  output logic                   fsm_in,
  output logic                   fsm_rst_n,
  input  logic [1:0]             fsm_out,
  output logic [2*N-1:0]         result,
  output logic [$clog2(N+1)-1:0] cnt1,
  output logic [$clog2(N+1)-1:0] cnt2
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N+1);
  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   bit_q, bit_d;
  logic [DW-1:0]   drn_q, drn_d;
  logic [N-1:0]    pat_q, pat_d;
  logic            accept;

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            fsm_in_q, fsm_in_d;
  logic            fsm_rst_n_q, fsm_rst_n_d;
  logic [2*N-1:0]  result_q, result_d;
  logic [CW-1:0]   cnt1_q, cnt1_d;
  logic [CW-1:0]   cnt2_q, cnt2_d;

  logic            cap_vld;
  logic [IW-1:0]   cap_idx;

  // Each SHIFT cycle launches one bit into the pipe; it pops out when the FSM answer is valid
  fsm_capture_pipe #(
    .LAT (LAT),
    .IW  (IW)
  ) u_capture_pipe (
    .clk   (clk),
    .rst   (rst),
    .vld_i (state_q == SHIFT),
    .idx_i (bit_q),
    .vld_o (cap_vld),
    .idx_o (cap_idx)
  );

  // Next-state logic plus the registered-output values derived from the next state
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    drn_d   = drn_q;
    pat_d   = pat_q;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          pat_d   = pattern;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (bit_q == IW'(N-1)) begin
          drn_d   = '0;
          state_d = DRAIN;
        end else begin
          bit_d = bit_q + IW'(1);
        end
      end
      DRAIN: begin
        if (drn_q == DW'(LAT-1)) begin
          state_d = DONE;
        end else begin
          drn_d = drn_q + DW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d == CLEAR) || (state_d == SHIFT) || (state_d == DRAIN);
    done_d      = (state_d == DONE);
    fsm_rst_n_d = (state_d != CLEAR);
    fsm_in_d    = (state_d == SHIFT) ? pat_d[bit_d] : 1'b0;
  end

  // Result slot write and symbol counting when a tracked bit's output arrives
  always_comb begin
    result_d = result_q;
    cnt1_d   = cnt1_q;
    cnt2_d   = cnt2_q;
    if (accept) begin
      result_d = '0;
      cnt1_d   = '0;
      cnt2_d   = '0;
    end else if (cap_vld) begin
      result_d[{cap_idx, 1'b0} +: 2] = fsm_out;
      if (fsm_out == SYM1) begin
        cnt1_d = cnt1_q + CW'(1);
      end
      if (fsm_out == SYM2) begin
        cnt2_d = cnt2_q + CW'(1);
      end
    end
  end

  // Controller state, bit index, drain counter and latched pattern
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      drn_q   <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      drn_q   <= drn_d;
      pat_q   <= pat_d;
    end
  end

  // Registered outputs so nothing the host or FSM sees is combinational
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fsm_in_q    <= 1'b0;
      fsm_rst_n_q <= 1'b1;
      result_q    <= '0;
      cnt1_q      <= '0;
      cnt2_q      <= '0;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      fsm_in_q    <= fsm_in_d;
      fsm_rst_n_q <= fsm_rst_n_d;
      result_q    <= result_d;
      cnt1_q      <= cnt1_d;
      cnt2_q      <= cnt2_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fsm_in    = fsm_in_q;
  assign fsm_rst_n = fsm_rst_n_q;
  assign result    = result_q;
  assign cnt1      = cnt1_q;
  assign cnt2      = cnt2_q;

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Bench for fsm_seq_ctrl: a LAT=1 instance and a LAT=3 instance, each with a
// stub FSM that echoes fsm_in as symbol 1 (or symbol 2 in mode2) after LAT cycles.
module tb_fsm_seq_ctrl;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       startReq;
  logic       useLat3;
  logic       stubMode2;
  logic [7:0] pattern;

  logic        start1, start3;
  logic        busy1, done1, fsmIn1, fsmRstN1;
  logic        busy3, done3, fsmIn3, fsmRstN3;
  logic [15:0] result1, result3;
  logic [3:0]  cntOne1, cntTwo1, cntOne3, cntTwo3;
  logic [1:0]  stubOut1;
  logic [1:0]  stubA3, stubB3, stubOut3;

  logic        obsBusy, obsDone, obsRstN;
  logic [15:0] obsResult;
  logic [3:0]  obsCnt1, obsCnt2;

  int total;
  int bad;

  typedef struct {
    logic [7:0]  pat;
    logic        mode2;
    logic [15:0] expRes;
    logic [3:0]  expC1;
    logic [3:0]  expC2;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  assign start1 = startReq & ~useLat3;
  assign start3 = startReq & useLat3;

  assign obsBusy   = useLat3 ? busy3    : busy1;
  assign obsDone   = useLat3 ? done3    : done1;
  assign obsRstN   = useLat3 ? fsmRstN3 : fsmRstN1;
  assign obsResult = useLat3 ? result3  : result1;
  assign obsCnt1   = useLat3 ? cntOne3  : cntOne1;
  assign obsCnt2   = useLat3 ? cntTwo3  : cntTwo1;

  fsm_seq_ctrl #(.N(N), .LAT(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .pattern   (pattern),
    .busy      (busy1),
    .done      (done1),
    .fsm_in    (fsmIn1),
    .fsm_rst_n (fsmRstN1),
    .fsm_out   (stubOut1),
    .result    (result1),
    .cnt1      (cntOne1),
    .cnt2      (cntTwo1)
  );

  fsm_seq_ctrl #(.N(N), .LAT(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .start     (start3),
    .pattern   (pattern),
    .busy      (busy3),
    .done      (done3),
    .fsm_in    (fsmIn3),
    .fsm_rst_n (fsmRstN3),
    .fsm_out   (stubOut3),
    .result    (result3),
    .cnt1      (cntOne3),
    .cnt2      (cntTwo3)
  );

  // One-cycle stub FSM for the LAT=1 instance
  always_ff @(posedge clk) begin
    stubOut1 <= stubMode2 ? {fsmIn1, 1'b0} : {1'b0, fsmIn1};
  end

  // Three-cycle stub FSM for the LAT=3 instance
  always_ff @(posedge clk) begin
    stubA3   <= stubMode2 ? {fsmIn3, 1'b0} : {1'b0, fsmIn3};
    stubB3   <= stubA3;
    stubOut3 <= stubB3;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Raise start for one cycle (or keep it high) from an IDLE negedge; returns mid cycle 1
  task automatic applyStimulus(input logic [7:0] pat, input bit holdStart);
    @(negedge clk);
    pattern  = pat;
    startReq = 1'b1;
    @(negedge clk);
    if (!holdStart) startReq = 1'b0;
  endtask

  // Walk from cycle 1 to the done cycle, optionally poking start/pattern mid-run
  task automatic waitDone(input int disturbAt, output int doneCyc);
    int cyc;
    int rstLow;
    cyc    = 1;
    rstLow = (obsRstN == 1'b0) ? 1 : 0;
    check("busyInClear", {31'd0, obsBusy}, 32'd1);
    while (obsDone !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (disturbAt != 0 && cyc == disturbAt) begin
        startReq = 1'b1;
        pattern  = ~pattern;
      end
      if (disturbAt != 0 && cyc == disturbAt + 1) startReq = 1'b0;
      if (obsRstN == 1'b0) rstLow++;
    end
    check("doneSeen", {31'd0, obsDone}, 32'd1);
    check("busyInDone", {31'd0, obsBusy}, 32'd0);
    check("rstLowCycles", rstLow, 32'd1);
    doneCyc = cyc;
  endtask

  task automatic checkOutput(input logic [15:0] expRes, input logic [3:0] c1, input logic [3:0] c2);
    check("result", {16'd0, obsResult}, {16'd0, expRes});
    check("cnt1", {28'd0, obsCnt1}, {28'd0, c1});
    check("cnt2", {28'd0, obsCnt2}, {28'd0, c2});
  endtask

  initial begin
    int dc;
    int doneHigh;
    int busyHigh;

    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    startReq  = 1'b0;
    useLat3   = 1'b0;
    stubMode2 = 1'b0;
    pattern   = 8'h00;

    vecs[0] = '{8'hB1, 1'b0, 16'h4501, 4'd4, 4'd0};
    vecs[1] = '{8'h00, 1'b0, 16'h0000, 4'd0, 4'd0};
    vecs[2] = '{8'hFF, 1'b1, 16'hAAAA, 4'd0, 4'd8};
    vecs[3] = '{8'hFF, 1'b0, 16'h5555, 4'd8, 4'd0};
    vecs[4] = '{8'h5A, 1'b1, 16'h2288, 4'd0, 4'd4};
    vecs[5] = '{8'h80, 1'b0, 16'h4000, 4'd1, 4'd0};
    vecs[6] = '{8'h01, 1'b1, 16'h0002, 4'd0, 4'd1};

    #12;
    check("resetBusy", {31'd0, busy1}, 32'd0);
    check("resetDone", {31'd0, done1}, 32'd0);
    check("resetFsmIn", {31'd0, fsmIn1}, 32'd0);
    check("resetFsmRstN", {31'd0, fsmRstN1}, 32'd1);
    checkOutput(16'h0000, 4'd0, 4'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      stubMode2 = vecs[i].mode2;
      applyStimulus(vecs[i].pat, 1'b0);
      waitDone(0, dc);
      check("doneCycle", dc, 32'd11);
      checkOutput(vecs[i].expRes, vecs[i].expC1, vecs[i].expC2);
      @(negedge clk);
      check("holdAfterDone", {16'd0, obsResult}, {16'd0, vecs[i].expRes});
    end

    $display("[TB] start pulse and pattern change during SHIFT");
    stubMode2 = 1'b0;
    applyStimulus(8'hB1, 1'b0);
    waitDone(4, dc);
    check("disturbDoneCycle", dc, 32'd11);
    checkOutput(16'h4501, 4'd4, 4'd0);
    @(negedge clk);
    check("noRestartBusy", {31'd0, obsBusy}, 32'd0);

    $display("[TB] start held high through DONE");
    applyStimulus(8'h0F, 1'b1);
    waitDone(0, dc);
    check("holdRun1Cycle", dc, 32'd11);
    checkOutput(16'h0055, 4'd4, 4'd0);
    pattern = 8'hF0;
    @(negedge clk);
    check("idleGapBusy", {31'd0, obsBusy}, 32'd0);
    check("idleGapDone", {31'd0, obsDone}, 32'd0);
    @(negedge clk);
    check("retriggerBusy", {31'd0, obsBusy}, 32'd1);
    check("retriggerRstN", {31'd0, obsRstN}, 32'd0);
    startReq = 1'b0;
    waitDone(0, dc);
    check("holdRun2Cycle", dc, 32'd11);
    checkOutput(16'h5500, 4'd4, 4'd0);

    $display("[TB] reset in third SHIFT cycle");
    applyStimulus(8'hB1, 1'b0);
    repeat (3) @(negedge clk);
    check("midRunResult", {16'd0, obsResult}, 32'h0001);
    rst = 1'b0;
    #1;
    check("rstBusy", {31'd0, obsBusy}, 32'd0);
    check("rstDone", {31'd0, obsDone}, 32'd0);
    check("rstFsmRstN", {31'd0, obsRstN}, 32'd1);
    check("rstFsmIn", {31'd0, fsmIn1}, 32'd0);
    checkOutput(16'h0000, 4'd0, 4'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    doneHigh = 0;
    busyHigh = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (obsDone) doneHigh++;
      if (obsBusy) busyHigh++;
    end
    check("noDoneAfterRst", doneHigh, 32'd0);
    check("noBusyAfterRst", busyHigh, 32'd0);
    applyStimulus(8'hB1, 1'b0);
    waitDone(0, dc);
    check("postRstCycle", dc, 32'd11);
    checkOutput(16'h4501, 4'd4, 4'd0);

    $display("[TB] LAT=3 instance");
    @(negedge clk);
    useLat3 = 1'b1;
    applyStimulus(8'hB1, 1'b0);
    waitDone(0, dc);
    check("lat3DoneCycle", dc, 32'd13);
    checkOutput(16'h4501, 4'd4, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsm_seq_ctrl.md
# fsm_seq_ctrl

Sequencer for the team's 1-bit-in / 2-bit-out Mealy sequence FSM. It accepts a parallel N-bit pattern with a start/busy/done handshake and forces the FSM back to its initial state. It then drives the pattern into the FSM one bit per cycle, LSB first, and collects every 2-bit FSM output into a result word plus per-symbol counters. It sits between a host or test harness and one FSM instance, and owns that FSM's input and its restart.

## Interface
- N, 8: pattern length in bits; legal range 2..32.
- LAT, 1: cycles from a bit being driven on fsm_in to its fsm_out being valid; legal range 1..4.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- pattern  in  N  bits to apply; latched on the accepted start.
- busy  out  1  high in CLEAR, SHIFT and DRAIN.
- done  out  1  one-cycle pulse in DONE.
- fsm_in  out  1  serial bit to the FSM.
- fsm_rst_n  out  1  FSM restart, active-low; low only in CLEAR.
- fsm_out  in  2  FSM output.
- result  out  2N  the output for bit k is held in result[2k+1:2k].
- cnt1  out  $clog2(N+1)  number of captured outputs equal to 1.
- cnt2  out  $clog2(N+1)  number of captured outputs equal to 2.

## Operation
- All outputs are registered.
- Reset values:
  - busy=0, done=0, fsm_in=0, fsm_rst_n=1.
  - result=0, cnt1=0, cnt2=0.
  - state=IDLE.
- IDLE: on start=1, latch pattern, clear result, cnt1 and cnt2, and go to CLEAR. With start=0, stay in IDLE.
- CLEAR (1 cycle): fsm_rst_n=0 and fsm_in=0. Next state is SHIFT, with bit index 0.
- SHIFT (N cycles): fsm_in=pattern[k] in the k-th SHIFT cycle. After k=N-1, go to DRAIN.
- DRAIN (LAT cycles): fsm_in=0. Finishes the outstanding captures, then goes to DONE.
- DONE (1 cycle): done=1 and busy=0. Next state is IDLE.
- Capture rule:
  - If bit k is driven during cycle c, sample fsm_out at the rising edge ending cycle c+LAT.
  - Write the sample to result[2k+1:2k].
  - Increment cnt1 if the sample is 1, and cnt2 if it is 2. Samples of 0 and 3 are stored but not counted.
- Tracking: a LAT-deep valid/index pipeline follows each driven bit. Captures never occur for CLEAR or DRAIN cycles.
- result, cnt1 and cnt2 hold their values from DONE until the next accepted start.
- A start while busy, or in DONE, is ignored. A start held high re-triggers on the first IDLE cycle.
- Changes on pattern after the accepted start have no effect.
- rst asserted mid-operation: every output goes immediately to its reset value and no done is issued.

## Timing
- Cycle numbering: edge E0 accepts start.
  - CLEAR is cycle 1.
  - SHIFT is cycles 2..N+1.
  - DRAIN is cycles N+2..N+1+LAT.
  - DONE is cycle N+2+LAT.
- start-to-done latency is N+2+LAT cycles. busy is high for N+1+LAT cycles.
- The last capture happens at the edge ending cycle N+1+LAT, so result is final when done is high.
- Back-to-back throughput is one run per N+3+LAT cycles, because IDLE lasts at least one cycle.

## Structure
- Shared package fsm_pkg holds:
  - the state enum IDLE/CLEAR/SHIFT/DRAIN/DONE,
  - the FSM symbol constants SYM0..SYM3 = 0..3,
  - the parameter range limits.
- Sub-module fsm_capture_pipe: a LAT-deep valid+index delay line that emits the (valid, k) pair telling the parent which result slot to write.
- Counters and the bit index are sized with $clog2.

## Test plan
Use a stub FSM model: fsm_out <= {1'b0, fsm_in} registered, with LAT=1 and N=8.

- Basic run: pattern=8'hB1 with a start pulse -> done at cycle 11, result=16'h4501, cnt1=4, cnt2=0. fsm_rst_n is low only in cycle 1.
- All zeros: pattern=8'h00 -> result=16'h0000, cnt1=0, cnt2=0.
- Stub changed to output 2 when fsm_in=1, pattern=8'hFF -> result=16'hAAAA, cnt2=8, cnt1=0.
- start pulsed during SHIFT, and pattern changed mid-run -> no restart, result reflects the latched pattern. A start held high through DONE -> a second run begins after one IDLE cycle.
- rst pulled low in the third SHIFT cycle -> busy, done, result and counters are 0 at once. A new start afterwards completes normally.
- LAT=3 with a matching 3-cycle stub -> done at cycle 13 and result identical to the basic run.
